// File: rtl/fetch_unit.sv
// Instruction fetch: issues one memory read per instruction, holds it for the decoder, and handles redirects.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'd0,
  parameter int          ADDR_LIMIT = 1024
) (
  input  logic        CLK,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  input  logic [15:0] mem_data,
  input  logic        mem_busy,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic [15:0] pc
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  localparam logic [15:0] LIM = 16'(ADDR_LIMIT);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic [15:0] pc_inc, redir_pc;

  assign pc_inc   = (pc_q + 16'd1) % LIM;
  assign redir_pc = redirect_pc % LIM;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    mem_read   = 1'b0;
    // Redirect wins over every state; data returning in WAIT is simply dropped.
    if (redirect) begin
      pc_d       = redir_pc;
      ir_valid_d = 1'b0;
      state_d    = ISSUE;
    end else begin
      case (state_q)
        IDLE:  state_d = ISSUE;
        ISSUE: if (!mem_busy) begin
          mem_read = 1'b1;
          state_d  = WAIT;
        end
        WAIT: begin
          ir_d       = mem_data;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_inc;
          state_d    = HOLD;
        end
        HOLD: if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = ISSUE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Keep the port quiet while held in reset so memory can be preloaded.
    if (reset) mem_read = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 16'd0;
      ir_pc_q    <= 16'd0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign pc       = pc_q;
  assign mem_addr = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_ev;

  always_comb begin
    stall_ev = ((state_q == ISSUE) && mem_busy) ||
               ((state_q == HOLD) && ir_valid_q && !ir_ready);
    stall_d  = stall_q;
    if (stall_ev && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (reset) stall_q <= 16'd0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus randomized traffic checked by a
// stream-level scoreboard (accepted instructions must follow pc, pc+1, ... restarting at redirect/reset targets).
module tb_fetch_unit;
  localparam logic [15:0] RPC = 16'd0;
  localparam int          L   = 1024;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr, mem_data, ir, ir_pc, pc, redirect_pc;
  logic        mem_read, mem_busy, ir_valid, ir_ready, redirect;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fetch_unit #(.RESET_PC(RPC), .ADDR_LIMIT(L)) dut (
    .CLK(CLK),
    .reset(reset),
    .mem_addr(mem_addr),
    .mem_read(mem_read),
    .mem_data(mem_data),
    .mem_busy(mem_busy),
    .ir(ir),
    .ir_pc(ir_pc),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .pc(pc)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] mem [0:L-1];

  // Synchronous-read memory: data appears the cycle after the read is sampled.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_read) mem_data <= mem[mem_addr[9:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ir_valid && n < 20);
    if (!ir_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic find_issue();
    int b;
    b = 0;
    do begin
      step();
      b++;
    end while (!mem_read && b < 20);
    if (!mem_read) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  // Monitor/scoreboard: expected next accepted address kept in a queue.
  logic [15:0] exp_q [$];
  logic        prev_reset = 1'b0, prev_hold = 1'b0;
  logic [15:0] prev_ir, prev_ir_pc;

  always @(negedge CLK) begin
    logic [15:0] e;
    if (cyc > 0) begin
      chk("mem_addr_eq_pc", {16'd0, mem_addr}, {16'd0, pc});
      if (reset || mem_busy || redirect) chk("mem_read_blocked", {31'd0, mem_read}, 32'd0);
      if (prev_reset) begin
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_pc", {16'd0, pc}, {16'd0, RPC});
      end
      if (prev_hold) begin
        chk("hold_valid", {31'd0, ir_valid}, 32'd1);
        chk("hold_ir", {16'd0, ir}, {16'd0, prev_ir});
        chk("hold_ir_pc", {16'd0, ir_pc}, {16'd0, prev_ir_pc});
      end
      if (reset) begin
        exp_q.delete();
        exp_q.push_back(RPC);
      end else begin
        if (ir_valid && ir_ready) begin
          if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("sb_ir_pc", {16'd0, ir_pc}, {16'd0, e});
            chk("sb_ir", {16'd0, ir}, {16'd0, mem[e[9:0]]});
            exp_q.push_back(16'((e + 1) % L));
          end
        end
        if (redirect) begin
          exp_q.delete();
          exp_q.push_back(16'(redirect_pc % L));
        end
      end
      prev_reset = reset;
      prev_hold  = ir_valid && !ir_ready && !redirect && !reset;
      prev_ir    = ir;
      prev_ir_pc = ir_pc;
    end
  end

  initial begin : main
    int          n;
    logic [15:0] seq [3];
    logic [15:0] old_ir, hold_ir, hold_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] base;
`endif
    seq[0] = 16'h0327; seq[1] = 16'h2027; seq[2] = 16'h4413;
    for (int i = 0; i < L; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) mem[i] = seq[i];
    mem_busy = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'd0;

    // Reset state
    repeat (3) step();
    #1;
    chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
    chk("reset_ir", {16'd0, ir}, 32'd0);
    chk("reset_ir_pc", {16'd0, ir_pc}, 32'd0);
    chk("reset_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("reset_pc", {16'd0, pc}, {16'd0, RPC});

    // Preloaded program: timing and order
    step();
    reset = 1'b0;
    wait_valid(n);
    chk("first_valid_cycle", n, 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        wait_valid(n);
        chk("valid_spacing", n, 32'd3);
      end
      chk("seq_ir", {16'd0, ir}, {16'd0, seq[k]});
      chk("seq_ir_pc", {16'd0, ir_pc}, k);
    end

    // mem_busy for 4 cycles in ISSUE
    step();
    mem_busy = 1'b1;
`ifdef FETCH_STALL_CNT_EN
    base = stall_cnt;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #1;
      chk("busy_no_read", {31'd0, mem_read}, 32'd0);
    end
    step();
    mem_busy = 1'b0;
    #1;
    chk("busy_release_read", {31'd0, mem_read}, 32'd1);
    chk("busy_release_addr", {16'd0, mem_addr}, 32'd3);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_busy", {16'd0, 16'(stall_cnt - base)}, 32'd4);
`endif

    // ir_ready low for 5 cycles in HOLD
    ir_ready = 1'b0;
    wait_valid(n);
    hold_ir = ir; hold_pc = ir_pc;
    chk("hold_first_pc", {16'd0, ir_pc}, 32'd3);
`ifdef FETCH_STALL_CNT_EN
    base = stall_cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      #1;
      chk("stall_ir", {16'd0, ir}, {16'd0, hold_ir});
      chk("stall_ir_pc", {16'd0, ir_pc}, {16'd0, hold_pc});
      chk("stall_no_read", {31'd0, mem_read}, 32'd0);
    end
    step();
    chk("stall_still_valid", {31'd0, ir_valid}, 32'd1);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_hold", {16'd0, 16'(stall_cnt - base)}, 32'd5);
`endif
    ir_ready = 1'b1;

    // Redirect during WAIT drops the in-flight data
    find_issue();
    old_ir = ir;
    step();
    redirect = 1'b1; redirect_pc = 16'd9;
    #1;
    chk("redir_no_read", {31'd0, mem_read}, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("redir_addr", {16'd0, mem_addr}, 32'd9);
    chk("redir_valid", {31'd0, ir_valid}, 32'd0);
    chk("redir_ir_kept", {16'd0, ir}, {16'd0, old_ir});
    chk("redir_read", {31'd0, mem_read}, 32'd1);
    wait_valid(n);
    chk("redir_ir_pc", {16'd0, ir_pc}, 32'd9);
    chk("redir_ir", {16'd0, ir}, {16'd0, mem[9]});

    // PC wrap at ADDR_LIMIT-1 (redirect coincides with an accept)
    redirect = 1'b1; redirect_pc = 16'd1023;
    step();
    redirect = 1'b0;
    #1;
    chk("wrap_addr_top", {16'd0, mem_addr}, 32'd1023);
    wait_valid(n);
    chk("wrap_ir_pc", {16'd0, ir_pc}, 32'd1023);
    chk("wrap_pc", {16'd0, pc}, 32'd0);
    chk("wrap_mem_addr", {16'd0, mem_addr}, 32'd0);
    wait_valid(n);
    chk("wrap_next_ir_pc", {16'd0, ir_pc}, 32'd0);

    // Reset asserted in WAIT
    find_issue();
    step();
    reset = 1'b1;
    #1;
    chk("rstw_no_read", {31'd0, mem_read}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("rstw_valid", {31'd0, ir_valid}, 32'd0);
      chk("rstw_pc", {16'd0, pc}, {16'd0, RPC});
      chk("rstw_read", {31'd0, mem_read}, 32'd0);
    end
    step();
    reset = 1'b0;
    wait_valid(n);
    chk("rstw_restart_cycle", n, 32'd3);
    chk("rstw_restart_pc", {16'd0, ir_pc}, {16'd0, RPC});
    chk("rstw_restart_ir", {16'd0, ir}, {16'd0, mem[RPC[9:0]]});

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      step();
      ir_ready = ($urandom_range(0, 9) < 7);
      mem_busy = ($urandom_range(0, 9) < 2);
      redirect = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc = 16'($urandom);
        1:       redirect_pc = 16'(1020 + $urandom_range(0, 3));
        default: redirect_pc = 16'($urandom_range(0, 15));
      endcase
      reset = ($urandom_range(0, 99) == 0);
    end
    step();
    reset = 1'b0; redirect = 1'b0; mem_busy = 1'b0; ir_ready = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
